// File: rtl/video_pkg.sv
// Shared types for the bicubic incremental-calc coefficient path (loader and calculator).
package video_pkg;

    localparam int unsigned N_COEFF = 26;
    localparam int unsigned W       = 32;
    localparam int unsigned IDX_W   = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEFF - 1);

    typedef logic signed [W-1:0] coeff_t;
    typedef coeff_t [N_COEFF-1:0] coeff_set_t;

    typedef enum logic [1:0] {
        StFill,
        StDrain,
        StFull
    } fill_state_t;

endpackage

// File: rtl/video_coeff_loader.sv
// Collects one 26-word coefficient set per tile, double-buffers it and issues go to the
// coordinate calculator when it is idle.
module video_coeff_loader
    import video_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [W-1:0]         s_data,
    input  logic                 s_last,
    input  logic                 calc_busy,
    output logic                 go,
    output logic [N_COEFF*W-1:0] coeff,
    output logic                 err_len,
    output logic [15:0]          tiles_issued
);

    fill_state_t      state_q;
    logic [IDX_W-1:0] idx_q;
    logic             s_ready_q;
    logic             go_q;
    logic             err_q;
    logic             ack_pend_q;
    logic [15:0]      tiles_q;
    coeff_set_t       shadow_q;
    coeff_set_t       coeff_q;

    logic accept;
    logic issue;

    assign accept = s_valid & s_ready_q;
    // ack_pend blocks re-issue until the calculator has acknowledged with busy.
    assign issue  = (state_q == StFull) & ~calc_busy & ~ack_pend_q;

    // Shadow buffer needs no reset; its contents only matter once a full set is collected.
    always_ff @(posedge clk) begin
        if (state_q == StFill && accept) begin
            shadow_q[idx_q] <= coeff_t'(s_data);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StFill;
            idx_q      <= '0;
            s_ready_q  <= 1'b0;
            go_q       <= 1'b0;
            err_q      <= 1'b0;
            ack_pend_q <= 1'b0;
            tiles_q    <= '0;
            coeff_q    <= '0;
        end else begin
            go_q  <= 1'b0;
            err_q <= 1'b0;
            if (calc_busy) begin
                ack_pend_q <= 1'b0;
            end
            unique case (state_q)
                StFill: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (s_last) begin
                                state_q   <= StFull;
                                s_ready_q <= 1'b0;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= StDrain;
                            end
                        end else if (s_last) begin
                            err_q <= 1'b1;
                            idx_q <= '0;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                StDrain: begin
                    s_ready_q <= 1'b1;
                    if (accept && s_last) begin
                        state_q <= StFill;
                        idx_q   <= '0;
                    end
                end
                StFull: begin
                    s_ready_q <= 1'b0;
                    if (issue) begin
                        coeff_q    <= shadow_q;
                        go_q       <= 1'b1;
                        tiles_q    <= tiles_q + 16'd1;
                        ack_pend_q <= 1'b1;
                        state_q    <= StFill;
                        s_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StFill;
                    idx_q     <= '0;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign go           = go_q;
    assign err_len      = err_q;
    assign tiles_issued = tiles_q;
    assign coeff        = coeff_q;

endmodule

// File: tb/tb_video_coeff_loader.sv
// Scoreboard bench for video_coeff_loader: expected sets are queued, a monitor checks each go.
module tb_video_coeff_loader;
    import video_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [W-1:0]         s_data = '0;
    logic                 s_last = 1'b0;
    logic                 calc_busy = 1'b0;
    logic                 go;
    logic [N_COEFF*W-1:0] coeff;
    logic                 err_len;
    logic [15:0]          tiles_issued;

    always #5 clk = ~clk;

    video_coeff_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .calc_busy    (calc_busy),
        .go           (go),
        .coeff        (coeff),
        .err_len      (err_len),
        .tiles_issued (tiles_issued)
    );

    typedef struct {
        logic [N_COEFF*W-1:0] set;
        logic [15:0]          tiles;
    } exp_t;

    exp_t                 exp_q[$];
    exp_t                 mon_e;
    logic [15:0]          exp_tiles = '0;
    int                   err_seen = 0;
    int                   n_vec = 0;
    int                   n_bad = 0;
    logic [N_COEFF*W-1:0] prev_coeff = '0;
    logic [N_COEFF*W-1:0] set1, set2, set3, set4, set5, set6, set7, junk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic logic [N_COEFF*W-1:0] mk_set(input logic [31:0] base,
                                                    input logic [31:0] step);
        logic [N_COEFF*W-1:0] s;
        for (int k = 0; k < N_COEFF; k++) s[k*W +: W] = base + 32'(k) * step;
        return s;
    endfunction

    // Monitor: every go must match the oldest queued set; coeff may only move with go.
    always @(negedge clk) begin
        if (reset_n) begin
            if (go) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_go", 64'(go), 64'(1'b0));
                end else begin
                    int bad;
                    bad = 0;
                    mon_e = exp_q.pop_front();
                    for (int k = N_COEFF - 1; k >= 0; k--)
                        if (coeff[k*W +: W] !== mon_e.set[k*W +: W]) bad = k;
                    check($sformatf("go_coeff[%0d]", bad), 64'(coeff[bad*W +: W]),
                          64'(mon_e.set[bad*W +: W]));
                    check("go_tiles", 64'(tiles_issued), 64'(mon_e.tiles));
                end
            end
            if (coeff !== prev_coeff) check("coeff_moves_only_with_go", 64'(go), 64'(1'b1));
            if (err_len) err_seen++;
        end
        prev_coeff = coeff;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_set(input logic [N_COEFF*W-1:0] set, input int nwords, input int last_at);
        for (int k = 0; k < nwords; k++) begin
            int t;
            t = 0;
            s_valid = 1'b1;
            s_data  = (k < N_COEFF) ? set[k*W +: W] : 32'hDEAD_0000 + 32'(k);
            s_last  = (k == last_at);
            while (!s_ready && t < 2000) begin
                step(1);
                t++;
            end
            if (t >= 2000) check($sformatf("s_ready_timeout_word%0d", k), 64'(s_ready), 64'(1'b1));
            step(1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic push_exp(input logic [N_COEFF*W-1:0] set);
        exp_t e;
        exp_tiles++;
        e.set   = set;
        e.tiles = exp_tiles;
        exp_q.push_back(e);
    endtask

    task automatic calc_run(input int n);
        calc_busy = 1'b1;
        step(n);
        calc_busy = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        set1 = mk_set(32'h0, 32'h10000);
        set2 = mk_set(32'hFFFF_0000, 32'h0);
        set3 = mk_set(32'h0000_1000, 32'h1);
        set4 = mk_set(32'h2000_0000, 32'h3);
        set5 = mk_set(32'hABCD_0000, 32'h11);
        set6 = mk_set(32'h5555_0000, 32'h7);
        set7 = mk_set(32'h0123_4567, 32'h101);
        junk = mk_set(32'h7777_0000, 32'h5);

        // Reset state
        #12;
        check("reset_s_ready", 64'(s_ready), 64'(1'b0));
        check("reset_go", 64'(go), 64'(1'b0));
        check("reset_err_len", 64'(err_len), 64'(1'b0));
        check("reset_coeff_nonzero", 64'(|coeff), 64'(1'b0));
        check("reset_tiles", 64'(tiles_issued), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("s_ready_before_first_edge", 64'(s_ready), 64'(1'b0));
        step(1);
        check("s_ready_after_release", 64'(s_ready), 64'(1'b1));

        // Set 1: go two edges after the last word
        send_set(set1, 26, 25);
        check("go_not_before_e1", 64'(go), 64'(1'b0));
        check("s_ready_full", 64'(s_ready), 64'(1'b0));
        push_exp(set1);
        step(1);
        check("go_latency", 64'(go), 64'(1'b1));
        check("s_ready_with_go", 64'(s_ready), 64'(1'b1));
        check("coeff25_set1", 64'(coeff[25*W +: W]), 64'(32'h0019_0000));

        // Set 2 downloads while the calculator is busy
        calc_busy = 1'b1;
        send_set(set2, 26, 25);
        step(5);
        check("s_ready_full_busy", 64'(s_ready), 64'(1'b0));
        check("coeff_hold_w0", 64'(coeff[0*W +: W]), 64'(32'h0));
        check("coeff_hold_w25", 64'(coeff[25*W +: W]), 64'(32'h0019_0000));
        step(268);
        calc_busy = 1'b0;
        push_exp(set2);
        step(1);
        check("go_after_busy_fall", 64'(go), 64'(1'b1));
        check("coeff7_set2", 64'(coeff[7*W +: W]), 64'(32'hFFFF_0000));
        calc_run(3);

        // Short set: err_len, no go, then a clean set
        e0 = err_seen;
        send_set(junk, 11, 10);
        step(3);
        check("err_short_set", 64'(err_seen - e0), 64'(1));
        send_set(set3, 26, 25);
        push_exp(set3);
        step(3);
        check("set3_issued", 64'(exp_q.size()), 64'(0));
        calc_run(3);

        // Overlong set: one err at word 25, words 26..29 dropped
        e0 = err_seen;
        send_set(junk, 30, 29);
        step(3);
        check("err_long_set", 64'(err_seen - e0), 64'(1));
        send_set(set4, 26, 25);
        push_exp(set4);
        step(3);
        check("set4_issued", 64'(exp_q.size()), 64'(0));

        // Busy never rose: a second full set waits until busy pulses
        send_set(set5, 26, 25);
        step(20);
        check("s_ready_held_ack", 64'(s_ready), 64'(1'b0));
        check("tiles_before_ack", 64'(tiles_issued), 64'(4));
        push_exp(set5);
        calc_busy = 1'b1;
        step(1);
        calc_busy = 1'b0;
        check("no_issue_on_busy_edge", 64'(go), 64'(1'b0));
        step(1);
        check("go_after_busy_pulse", 64'(go), 64'(1'b1));
        calc_run(3);

        // Reset in the middle of a set
        send_set(set6, 12, 99);
        s_valid = 1'b1;
        s_data  = 32'h1234_5678;
        reset_n = 1'b0;
        #1;
        check("midreset_coeff_nonzero", 64'(|coeff), 64'(1'b0));
        check("midreset_go", 64'(go), 64'(1'b0));
        check("midreset_s_ready", 64'(s_ready), 64'(1'b0));
        check("midreset_tiles", 64'(tiles_issued), 64'(0));
        s_valid = 1'b0;
        exp_tiles = '0;
        step(2);
        reset_n = 1'b1;
        step(1);
        send_set(set7, 26, 25);
        push_exp(set7);
        step(3);
        check("set7_issued", 64'(exp_q.size()), 64'(0));
        check("tiles_after_reset", 64'(tiles_issued), 64'(1));
        check("err_total_after_reset", 64'(err_seen), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/video_coeff_loader.md
Name: video_coeff_loader

Overview:
- Producer side of the incremental-calc coefficient interface: collects one set of 26 signed 32-bit bicubic forward-difference coefficients per 16x16 tile from a valid/ready word stream.
- Double-buffers the set; presents it on a stable parallel bus and issues a one-cycle go to the coordinate calculator when that calculator is idle.
- Sits between the configuration/DMA word stream and video_calc_incr, so coefficient download for tile n+1 overlaps processing of tile n.

Parameters:
- N_COEFF, 26, coefficients per tile set; the word index is a 5-bit counter.
- W, 32, coefficient width in bits; signed, 16.16 fixed point, passed through unmodified.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  loader can accept a word
- s_data  in  W  coefficient word; k-th accepted word of a set -> coeff[k]
- s_last  in  1  marks the final word of a set
- calc_busy  in  1  calculator is processing (high from the cycle after go until its tile is done)
- go  out  1  one-cycle start pulse to the calculator
- coeff  out  N_COEFF*W  active set, packed; coeff[k] occupies bits [k*W +: W]
- err_len  out  1  one-cycle pulse on a malformed set
- tiles_issued  out  16  count of go pulses, wraps at 65535 -> 0

Behaviour:
- Reset (async, reset_n=0):
  - s_ready=0, go=0, err_len=0, coeff=0, tiles_issued=0.
  - Shadow buffer contents are don't-care; word index=0.
  - Fill FSM goes to FILL; ack_pend=0.
  - s_ready rises the first cycle after reset release.
- Transfer: a word moves on a rising edge with s_valid & s_ready. s_valid and s_ready are independent; there is no combinational path from s_valid to s_ready.
- Fill FSM states: FILL, DRAIN, FULL.
  - FILL: s_ready=1. An accepted word writes shadow[idx], then idx++.
    - idx==25 with s_last=1: go to FULL, idx=0.
    - idx<25 with s_last=1: pulse err_len, discard the partial set, idx=0, stay in FILL.
    - idx==25 with s_last=0: pulse err_len, discard, go to DRAIN.
  - DRAIN: s_ready=1; words are dropped. An accepted word with s_last=1 -> FILL, idx=0. No err_len pulse while in DRAIN.
  - FULL: s_ready=0. The set waits to be issued.
- Issue rule, on an edge where FSM==FULL, calc_busy=0 and ack_pend=0:
  - coeff <= shadow; go <= 1 for exactly one cycle; tiles_issued++.
  - ack_pend <= 1; FSM <= FILL, so s_ready is high in the same cycle go is high.
  - Minimum latency: word 25 accepted at edge E, go high during the cycle after edge E+1.
- ack_pend clears on the first edge where calc_busy=1. This prevents double issue before the calculator raises busy. While ack_pend=1, FULL holds.
- coeff changes only on the issue edge and is otherwise stable. The next set can fill the shadow buffer during calc_busy without disturbing coeff.
- Simultaneous events:
  - A word accepted on the issue edge belongs to the next set; a shadow write and the copy to coeff never conflict, because the FSM is in FULL, not FILL, on the issue edge.
  - calc_busy rising on the same edge as a pending issue: no issue.
- Reset mid-set or mid-issue: the partial set is lost and coeff=0; upstream restarts the set.

Decomposition:
- Shared package video_pkg: N_COEFF, W, coeff_t (logic signed [W-1:0]), coeff_set_t (coeff_t [N_COEFF-1:0]), and the fill-state enum. The calculator uses the same types.
- No sub-module. Shadow and active buffers are plain register arrays in this module.

Test Plan:
- Reset, then 26 words k*0x10000 with s_last on word 25, calc_busy=0 -> one go pulse 2 edges after the last word; coeff[0]=0, coeff[25]=0x190000; tiles_issued=1.
- Hold calc_busy=1 for 300 cycles after go; stream the second set (all 0xFFFF0000) -> FULL, s_ready=0, coeff unchanged; go fires 1 cycle after calc_busy falls; coeff[7]=0xFFFF0000.
- s_last on word 10 -> err_len pulse, no go; the following valid 26-word set -> normal go with the new values only.
- 30 words with s_last only on word 29 -> err_len once at word 25, words 26-29 dropped, no go; next set issues normally.
- calc_busy stays 0 after go while a second full set is ready -> no second go until calc_busy pulses high then low.
- Assert reset_n low mid-set (word 12) -> coeff=0, go=0, s_ready=0 immediately; after release, a full set issues go with tiles_issued=1.
